ticket_machine_param: RTL and testbench
=======================================

# ticket_machine_param

Parametrised ticket vending FSM, successor to the fixed-price 10/20 ticket machine. Accepts three coin denominations, accumulates credit in a counter rather than hard-coded states, and dispenses at a configurable price. Returns exact change, or refunds on cancel or inactivity timeout, and keeps a running sold-ticket count. Sits between the coin-acceptor front end and the ticket printer / change hopper.

## Interface
- PRICE, 3, ticket price in units of 10 (default = 30); legal range 1..60
- TIMEOUT, 255, idle cycles in COLLECT before automatic refund; 0 disables the timeout
- SOLD_W, 16, width of the sold-ticket counter
- clk  input  1  rising-edge clock
- clear  input  1  reset, asynchronous, active-high
- ten  input  1  10-unit coin strobe, one cycle per coin
- twenty  input  1  20-unit coin strobe
- fifty  input  1  50-unit coin strobe
- cancel  input  1  customer cancel request
- ready  output  1  machine idle, no credit held
- bill  output  1  collecting, credit > 0
- dispense  output  1  one-cycle ticket release pulse
- return_sig  output  1  one-cycle change/refund pulse
- change  output  CW  amount returned (units of 10), valid while return_sig=1, else 0; CW = $clog2(PRICE+5)
- credit  output  CW  current accumulated credit
- sold  output  SOLD_W  tickets dispensed since reset, wraps modulo 2^SOLD_W

## Operation
- Coin values: ten=1, twenty=2, fifty=5. If several strobes are high in one cycle, only the highest is accepted (fifty > twenty > ten); the others are dropped.
- Credit max = PRICE-1+5 = PRICE+4, so it never overflows CW.
- States: IDLE, COLLECT, DISPENSE, CHANGE, REFUND. Moore outputs, decoded from the registered state and credit.
- IDLE: ready=1. An accepted coin sets credit=v. Go to DISPENSE if v>=PRICE, else COLLECT. cancel is ignored.
- COLLECT: bill=1.
  - cancel has priority over coins: go to REFUND, and any coin that cycle is not credited.
  - Otherwise an accepted coin sets credit+=v and reloads the timeout counter. Go to DISPENSE if the new credit is >= PRICE.
  - With no coin and no cancel, the timeout counter increments. After TIMEOUT consecutive such cycles, go to REFUND.
- DISPENSE (1 cycle): dispense=1 and sold+=1. Then:
  - if credit>PRICE: credit-=PRICE and go to CHANGE;
  - otherwise credit=0 and go to IDLE.
- CHANGE (1 cycle): return_sig=1, change=credit. Then credit=0, go to IDLE.
- REFUND (1 cycle): return_sig=1, change=credit. Then credit=0, go to IDLE.
- Coins and cancel arriving in DISPENSE, CHANGE or REFUND are ignored and not credited (the coin acceptor rejects them mechanically).
- Illegal state encoding: go to IDLE with credit=0.

## Timing
- clear asserted, at any time including mid-transaction: immediately state=IDLE, credit=0, sold=0, timeout counter=0.
  - Output values during and after reset: ready=1, bill=0, dispense=0, return_sig=0, change=0.
  - Credit held at that moment is lost; no refund is issued.
- Coin sampled on edge N. The new state and its outputs are visible after edge N, and credit is updated on the same edge.
- Latency from the completing coin to the dispense pulse is 1 cycle. The change pulse follows in the next cycle. The machine is back in IDLE (ready=1) 1 or 2 cycles after dispense.
- Timeout, for TIMEOUT=T: the last coin is accepted on edge N. With no further coin or cancel, REFUND is entered on edge N+T.
- sold updates on the edge leaving DISPENSE. It wraps from 2^SOLD_W-1 to 0 with no flag.

## Structure
- Shared package ticket_pkg holds:
  - the state enum (IDLE, COLLECT, DISPENSE, CHANGE, REFUND);
  - coin value constants COIN_TEN=1, COIN_TWENTY=2, COIN_FIFTY=5.
- CW and the timeout counter width are localparams derived from PRICE and TIMEOUT.
- One sub-module, ticket_coin_decode: priority-encodes ten/twenty/fifty into a valid flag and a 3-bit value. It is purely combinational.
- Top level contains the state register, credit register, timeout counter and sold counter.

## Test plan
- PRICE=3: ten, ten, ten on consecutive cycles -> dispense pulse 1 cycle after third coin, no return_sig, ready next cycle, sold=1.
- PRICE=3: twenty, twenty -> dispense, then return_sig with change=1, then ready; sold=1.
- PRICE=3: single fifty from IDLE -> dispense next cycle, then return_sig with change=2.
- PRICE=3: ten then cancel (with twenty asserted simultaneously) -> REFUND, change=1, the twenty is not credited.
- PRICE=3, TIMEOUT=8: ten then 8 idle cycles -> return_sig with change=1 exactly 8 cycles after the coin edge; a coin at cycle 7 instead restarts the count.
- ten+twenty+fifty in the same cycle in IDLE -> only 5 credited (dispense, change=2). clear asserted mid-COLLECT with credit=2 -> ready=1, credit=0, no return_sig, sold=0.

Source files
------------

// File: rtl/ticket_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ticket_pkg
//  Description : Shared definitions for the parametrised ticket machine:
//                FSM state encoding and coin denomination values (units of 10).
//  Revision    : 1.0 - initial release
// ============================================================================
package ticket_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        COLLECT  = 3'd1,
        DISPENSE = 3'd2,
        CHANGE   = 3'd3,
        REFUND   = 3'd4
    } state_e;

    localparam logic [2:0] COIN_TEN    = 3'd1;
    localparam logic [2:0] COIN_TWENTY = 3'd2;
    localparam logic [2:0] COIN_FIFTY  = 3'd5;

endpackage : ticket_pkg
`default_nettype wire

// File: rtl/ticket_coin_decode.sv
`default_nettype none
// ============================================================================
//  Module      : ticket_coin_decode
//  Description : Combinational priority encoder for the coin strobes.
//                fifty beats twenty beats ten; lower coins seen in the same
//                cycle are dropped.
//  Ports       : ten_i, twenty_i, fifty_i - coin strobes from the acceptor
//                valid_o                  - at least one strobe is high
//                value_o                  - accepted coin value (units of 10)
//  Revision    : 1.0 - initial release
// ============================================================================
module ticket_coin_decode
    import ticket_pkg::*;
(
    input  logic       ten_i,
    input  logic       twenty_i,
    input  logic       fifty_i,
    output logic       valid_o,
    output logic [2:0] value_o
);

    always_comb begin
        valid_o = ten_i | twenty_i | fifty_i;
        if (fifty_i) begin
            value_o = COIN_FIFTY;
        end else if (twenty_i) begin
            value_o = COIN_TWENTY;
        end else if (ten_i) begin
            value_o = COIN_TEN;
        end else begin
            value_o = 3'd0;
        end
    end

endmodule : ticket_coin_decode
`default_nettype wire

// File: rtl/ticket_machine_param.sv
`default_nettype none
// ============================================================================
//  Module      : ticket_machine_param
//  Description : Parametrised ticket vending FSM. Accumulates coin credit,
//                dispenses at PRICE, returns exact change, refunds on cancel
//                or inactivity timeout, and counts tickets sold.
//  Ports       : clk, clear (async, active-high)
//                ten / twenty / fifty  - coin strobes (1 / 2 / 5 units)
//                cancel                - customer cancel request
//                ready, bill           - idle / collecting status
//                dispense, return_sig  - one-cycle ticket / change pulses
//                change                - amount returned while return_sig=1
//                credit                - current accumulated credit
//                sold                  - tickets dispensed, wraps silently
//  Revision    : 1.0 - initial release
// ============================================================================
module ticket_machine_param
    import ticket_pkg::*;
#(
    parameter int PRICE   = 3,
    parameter int TIMEOUT = 255,
    parameter int SOLD_W  = 16
) (
    input  logic                         clk,
    input  logic                         clear,
    input  logic                         ten,
    input  logic                         twenty,
    input  logic                         fifty,
    input  logic                         cancel,
    output logic                         ready,
    output logic                         bill,
    output logic                         dispense,
    output logic                         return_sig,
    output logic [$clog2(PRICE+5)-1:0]   change,
    output logic [$clog2(PRICE+5)-1:0]   credit,
    output logic [SOLD_W-1:0]            sold
);

    // Credit never exceeds PRICE+4 (PRICE-1 held plus a fifty), so CW bits
    // are always enough and the credit adder cannot overflow.
    localparam int            CW       = $clog2(PRICE + 5);
    localparam int            TW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit            TMO_EN   = (TIMEOUT > 0);
    localparam logic [CW-1:0] PRICE_C  = CW'(PRICE);
    localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_e              state_q, state_d;
    logic [CW-1:0]       credit_q, credit_d;
    logic [TW-1:0]       tmo_q, tmo_d;
    logic [SOLD_W-1:0]   sold_q, sold_d;

    logic                ready_q, bill_q, dispense_q, return_q;
    logic [CW-1:0]       change_q;

    logic                coin_valid;
    logic [2:0]          coin_value;
    logic [CW-1:0]       coin_ext;
    logic [CW-1:0]       credit_sum;

    ticket_coin_decode u_coin_decode (
        .ten_i    (ten),
        .twenty_i (twenty),
        .fifty_i  (fifty),
        .valid_o  (coin_valid),
        .value_o  (coin_value)
    );

    assign coin_ext   = CW'(coin_value);
    assign credit_sum = credit_q + coin_ext;

    // Next-state / next-credit logic.
    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        tmo_d    = tmo_q;
        sold_d   = sold_q;
        case (state_q)
            IDLE: begin
                tmo_d = '0;
                if (coin_valid) begin
                    credit_d = coin_ext;
                    state_d  = (coin_ext >= PRICE_C) ? DISPENSE : COLLECT;
                end else begin
                    credit_d = '0;
                end
            end
            COLLECT: begin
                // Cancel wins over any coin in the same cycle.
                if (cancel) begin
                    state_d = REFUND;
                    tmo_d   = '0;
                end else if (coin_valid) begin
                    credit_d = credit_sum;
                    tmo_d    = '0;
                    if (credit_sum >= PRICE_C) begin
                        state_d = DISPENSE;
                    end
                end else if (TMO_EN) begin
                    // Counter holds the number of quiet cycles already seen;
                    // the T-th quiet edge moves to REFUND.
                    if (tmo_q == TMO_LAST) begin
                        state_d = REFUND;
                        tmo_d   = '0;
                    end else begin
                        tmo_d = tmo_q + TW'(1);
                    end
                end
            end
            DISPENSE: begin
                sold_d = sold_q + SOLD_W'(1);
                tmo_d  = '0;
                if (credit_q > PRICE_C) begin
                    credit_d = credit_q - PRICE_C;
                    state_d  = CHANGE;
                end else begin
                    credit_d = '0;
                    state_d  = IDLE;
                end
            end
            CHANGE, REFUND: begin
                credit_d = '0;
                tmo_d    = '0;
                state_d  = IDLE;
            end
            default: begin
                credit_d = '0;
                tmo_d    = '0;
                state_d  = IDLE;
            end
        endcase
    end

    // State, counters and Moore outputs. Outputs are registered from the
    // next state so they line up exactly with the state they describe.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q    <= IDLE;
            credit_q   <= '0;
            tmo_q      <= '0;
            sold_q     <= '0;
            ready_q    <= 1'b1;
            bill_q     <= 1'b0;
            dispense_q <= 1'b0;
            return_q   <= 1'b0;
            change_q   <= '0;
        end else begin
            state_q    <= state_d;
            credit_q   <= credit_d;
            tmo_q      <= tmo_d;
            sold_q     <= sold_d;
            ready_q    <= (state_d == IDLE);
            bill_q     <= (state_d == COLLECT);
            dispense_q <= (state_d == DISPENSE);
            return_q   <= (state_d == CHANGE) || (state_d == REFUND);
            change_q   <= ((state_d == CHANGE) || (state_d == REFUND)) ? credit_d : '0;
        end
    end

    assign ready      = ready_q;
    assign bill       = bill_q;
    assign dispense   = dispense_q;
    assign return_sig = return_q;
    assign change     = change_q;
    assign credit     = credit_q;
    assign sold       = sold_q;

endmodule : ticket_machine_param
`default_nettype wire

// File: tb/tb_ticket_machine_param.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_ticket_machine_param
//  Description : Self-checking bench for ticket_machine_param (PRICE=3,
//                TIMEOUT=8, SOLD_W=4 so the sold counter wraps quickly).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ticket_machine_param;

    localparam int PRICE   = 3;
    localparam int TIMEOUT = 8;
    localparam int SOLD_W  = 4;
    localparam int CW      = $clog2(PRICE + 5);

    logic              clk = 1'b0;
    logic              clear = 1'b1;
    logic              ten = 1'b0, twenty = 1'b0, fifty = 1'b0, cancel = 1'b0;
    logic              ready, bill, dispense, return_sig;
    logic [CW-1:0]     change, credit;
    logic [SOLD_W-1:0] sold;

    always #5 clk = ~clk;

    ticket_machine_param #(
        .PRICE   (PRICE),
        .TIMEOUT (TIMEOUT),
        .SOLD_W  (SOLD_W)
    ) dut (
        .clk        (clk),
        .clear      (clear),
        .ten        (ten),
        .twenty     (twenty),
        .fifty      (fifty),
        .cancel     (cancel),
        .ready      (ready),
        .bill       (bill),
        .dispense   (dispense),
        .return_sig (return_sig),
        .change     (change),
        .credit     (credit),
        .sold       (sold)
    );

    typedef struct {
        logic ready;
        logic bill;
        logic disp;
        logic ret;
        int   change;
        int   credit;
        int   sold;
    } out_t;

    typedef struct {
        logic clr, t10, t20, t50, can;
        out_t exp;
    } vec_t;

    int vectors    = 0;
    int miscompares = 0;

    // ------------------------------------------------------------------
    // Reference model: a purchase is a scheduled list of future output
    // cycles (dispense, then maybe change; or a single refund). While the
    // list is non-empty the machine is busy and ignores the customer.
    // ------------------------------------------------------------------
    int   m_credit = 0;
    int   m_idle   = 0;
    int   m_sold   = 0;
    bit   m_collect = 1'b0;
    out_t m_q[$];

    function automatic out_t mk(input logic r, input logic b, input logic d,
                                input logic rt, input int ch, input int cr,
                                input int s);
        out_t o;
        o.ready = r; o.bill = b; o.disp = d; o.ret = rt;
        o.change = ch; o.credit = cr; o.sold = s;
        return o;
    endfunction

    function automatic out_t model_expect();
        out_t o;
        if (m_q.size() > 0) begin
            o = m_q[0];
        end else begin
            o = mk(!m_collect, m_collect, 1'b0, 1'b0, 0, m_credit, 0);
        end
        o.sold = m_sold;
        return o;
    endfunction

    task automatic model_refund();
        m_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, m_credit, m_credit, 0));
        m_credit  = 0;
        m_collect = 1'b0;
        m_idle    = 0;
    endtask

    task automatic model_step(input logic c, input logic t1, input logic t2,
                              input logic t5, input logic cn);
        int   v;
        out_t r;
        if (c) begin
            m_q.delete();
            m_credit = 0; m_idle = 0; m_sold = 0; m_collect = 1'b0;
            return;
        end
        if (m_q.size() > 0) begin
            r = m_q.pop_front();
            if (r.disp) m_sold = (m_sold + 1) % (1 << SOLD_W);
            return;
        end
        v = t5 ? 5 : (t2 ? 2 : (t1 ? 1 : 0));
        if (m_collect && cn) begin
            model_refund();
        end else if (v > 0) begin
            m_credit = m_credit + v;
            m_idle   = 0;
            if (m_credit >= PRICE) begin
                m_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 0, m_credit, 0));
                if (m_credit > PRICE)
                    m_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, m_credit - PRICE,
                                     m_credit - PRICE, 0));
                m_credit  = 0;
                m_collect = 1'b0;
            end else begin
                m_collect = 1'b1;
            end
        end else if (m_collect) begin
            m_idle++;
            if (TIMEOUT != 0 && m_idle == TIMEOUT) model_refund();
        end
    endtask

    // ------------------------------------------------------------------
    task automatic drive(input logic c, input logic t1, input logic t2,
                         input logic t5, input logic cn);
        @(negedge clk);
        clear = c; ten = t1; twenty = t2; fifty = t5; cancel = cn;
        @(posedge clk);
        model_step(c, t1, t2, t5, cn);
        #1;
    endtask

    task automatic check(input string name, input out_t e);
        vectors++;
        if (ready !== e.ready || bill !== e.bill || dispense !== e.disp ||
            return_sig !== e.ret || change !== CW'(e.change) ||
            credit !== CW'(e.credit) || sold !== SOLD_W'(e.sold)) begin
            miscompares++;
            $display("FAIL %s @%0t: got rdy=%0b bill=%0b disp=%0b ret=%0b chg=%0d cr=%0d sold=%0d, want rdy=%0b bill=%0b disp=%0b ret=%0b chg=%0d cr=%0d sold=%0d",
                     name, $time, ready, bill, dispense, return_sig, change, credit, sold,
                     e.ready, e.bill, e.disp, e.ret, e.change, e.credit, e.sold);
        end
    endtask

    vec_t tbl[$];

    task automatic add(input logic c, input logic t1, input logic t2,
                       input logic t5, input logic cn, input out_t e);
        vec_t v;
        v.clr = c; v.t10 = t1; v.t20 = t2; v.t50 = t5; v.can = cn; v.exp = e;
        tbl.push_back(v);
    endtask

    initial begin
        int rate;

        // ---------------- directed table (PRICE=3) ----------------
        //   clr t10 t20 t50 can        rdy bill disp ret chg cr sold
        add(1, 0, 0, 0, 0, mk(1, 0, 0, 0, 0, 0, 0));   // reset state
        add(0, 1, 0, 0, 0, mk(0, 1, 0, 0, 0, 1, 0));   // ten
        add(0, 1, 0, 0, 0, mk(0, 1, 0, 0, 0, 2, 0));   // ten
        add(0, 1, 0, 0, 0, mk(0, 0, 1, 0, 0, 3, 0));   // ten -> dispense
        add(0, 0, 0, 0, 0, mk(1, 0, 0, 0, 0, 0, 1));   // exact, back to idle
        add(0, 0, 1, 0, 0, mk(0, 1, 0, 0, 0, 2, 1));   // twenty
        add(0, 0, 1, 0, 0, mk(0, 0, 1, 0, 0, 4, 1));   // twenty -> dispense
        add(0, 0, 0, 0, 0, mk(0, 0, 0, 1, 1, 1, 2));   // change 1
        add(0, 0, 0, 0, 0, mk(1, 0, 0, 0, 0, 0, 2));
        add(0, 0, 0, 1, 0, mk(0, 0, 1, 0, 0, 5, 2));   // fifty from idle
        add(0, 0, 0, 0, 0, mk(0, 0, 0, 1, 2, 2, 3));   // change 2
        add(0, 0, 0, 0, 0, mk(1, 0, 0, 0, 0, 0, 3));
        add(0, 1, 0, 0, 0, mk(0, 1, 0, 0, 0, 1, 3));   // ten
        add(0, 0, 1, 0, 1, mk(0, 0, 0, 1, 1, 1, 3));   // cancel beats twenty
        add(0, 0, 0, 0, 0, mk(1, 0, 0, 0, 0, 0, 3));
        add(0, 1, 1, 1, 0, mk(0, 0, 1, 0, 0, 5, 3));   // all three -> 5 only
        add(0, 1, 0, 0, 0, mk(0, 0, 0, 1, 2, 2, 4));   // coin in dispense ignored
        add(0, 0, 0, 1, 0, mk(1, 0, 0, 0, 0, 0, 4));   // coin in change ignored
        add(0, 0, 0, 0, 1, mk(1, 0, 0, 0, 0, 0, 4));   // cancel in idle ignored
        add(0, 0, 1, 0, 0, mk(0, 1, 0, 0, 0, 2, 4));   // collect, credit 2
        add(1, 1, 0, 0, 0, mk(1, 0, 0, 0, 0, 0, 0));   // clear mid-collect
        add(0, 0, 0, 0, 0, mk(1, 0, 0, 0, 0, 0, 0));   // no refund after clear
        add(0, 0, 0, 1, 0, mk(0, 0, 1, 0, 0, 5, 0));
        add(0, 0, 0, 0, 1, mk(0, 0, 0, 1, 2, 2, 1));   // cancel in dispense ignored
        add(0, 0, 0, 0, 0, mk(1, 0, 0, 0, 0, 0, 1));

        foreach (tbl[i]) begin
            drive(tbl[i].clr, tbl[i].t10, tbl[i].t20, tbl[i].t50, tbl[i].can);
            check($sformatf("tbl[%0d]", i), tbl[i].exp);
        end

        // ---------------- timeout: coin then 8 quiet cycles ----------------
        drive(0, 1, 0, 0, 0);
        check("to_coin", mk(0, 1, 0, 0, 0, 1, 1));
        for (int i = 1; i < TIMEOUT; i++) begin
            drive(0, 0, 0, 0, 0);
            check($sformatf("to_wait%0d", i), mk(0, 1, 0, 0, 0, 1, 1));
        end
        drive(0, 0, 0, 0, 0);
        check("to_refund", mk(0, 0, 0, 1, 1, 1, 1));
        drive(0, 0, 0, 0, 0);
        check("to_idle", mk(1, 0, 0, 0, 0, 0, 1));

        // ---------------- timeout restart by a coin at cycle 7 ----------------
        drive(0, 1, 0, 0, 0);
        check("rs_coin", mk(0, 1, 0, 0, 0, 1, 1));
        for (int i = 1; i < 7; i++) begin
            drive(0, 0, 0, 0, 0);
            check($sformatf("rs_wait%0d", i), mk(0, 1, 0, 0, 0, 1, 1));
        end
        drive(0, 1, 0, 0, 0);
        check("rs_coin2", mk(0, 1, 0, 0, 0, 2, 1));
        for (int i = 1; i < TIMEOUT; i++) begin
            drive(0, 0, 0, 0, 0);
            check($sformatf("rs_wait2_%0d", i), mk(0, 1, 0, 0, 0, 2, 1));
        end
        drive(0, 0, 0, 0, 0);
        check("rs_refund", mk(0, 0, 0, 1, 2, 2, 1));
        drive(0, 0, 0, 0, 0);
        check("rs_idle", mk(1, 0, 0, 0, 0, 0, 1));

        // ---------------- asynchronous clear between edges ----------------
        drive(0, 1, 0, 0, 0);
        check("ac_coin", mk(0, 1, 0, 0, 0, 1, 1));
        @(negedge clk);
        clear = 1'b1; ten = 1'b0;
        #1;
        check("ac_immediate", mk(1, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        model_step(1, 0, 0, 0, 0);
        #1;
        check("ac_held", mk(1, 0, 0, 0, 0, 0, 0));
        drive(0, 0, 0, 0, 0);
        check("ac_release", mk(1, 0, 0, 0, 0, 0, 0));

        // ---------------- randomized run against the model ----------------
        drive(1, 0, 0, 0, 0);
        check("rnd_reset", model_expect());
        for (int blk = 0; blk < 40; blk++) begin
            // Alternate busy and sparse blocks so both purchases and
            // timeouts occur; sold (4 bits) wraps during the busy blocks.
            rate = (blk % 2 == 0) ? 40 : 3;
            for (int c = 0; c < 60; c++) begin
                drive($urandom_range(0, 999) == 0,
                      $urandom_range(0, 99) < rate,
                      $urandom_range(0, 99) < rate,
                      $urandom_range(0, 99) < rate / 2,
                      $urandom_range(0, 99) < rate / 4);
                check("rnd", model_expect());
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_ticket_machine_param
`default_nettype wire
